// File: rtl/up_down_counter_param.sv
// up_down_counter_param: modulo-N up/down counter with clock prescaler, parallel load, wrap/saturate ends and terminal flags.
// Define UDC_OVF_STICKY_EN to build the sticky overflow flag; otherwise ovf_stky is a constant 0.
module up_down_counter_param #(
    parameter int     WIDTH    = 4,
    parameter longint MODULO   = 16,
    parameter int     PRESCALE = 1,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_stky
);

    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc;
    logic             step;
    logic             terminal;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_clamped;

    assign step         = en & (presc == PLAST);
    assign terminal     = up ? (q == MAXV) : (q == '0);
    assign tc           = step & terminal;
    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    // Range ends either wrap around or hold, depending on SATURATE.
    always_comb begin
        q_next = q;
        if (up) begin
            if (q == MAXV) q_next = SATURATE ? MAXV : '0;
            else           q_next = q + 1'b1;
        end else begin
            if (q == '0)   q_next = SATURATE ? '0 : MAXV;
            else           q_next = q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            q     <= load_clamped;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            // tc is already gated by en, so wrap drops to 0 on idle cycles.
            wrap <= tc;
            if (en) begin
                if (step) begin
                    presc <= '0;
                    q     <= q_next;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

`ifdef UDC_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (reset || load) ovf_stky <= 1'b0;
        else if (tc)       ovf_stky <= 1'b1;
    end
`else
    assign ovf_stky = 1'b0;
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// Scoreboard bench: four counter configurations share one randomized/directed input stream
// and are compared against an arithmetic reference model held in the bench.
module tb_up_down_counter_param;

    localparam int N = 4;
    localparam int M_C [N] = '{16, 10, 10, 16};
    localparam int P_C [N] = '{1, 1, 1, 3};
    localparam int S_C [N] = '{0, 0, 1, 0};

    typedef struct packed {
        logic [N-1:0][3:0] q;
        logic [N-1:0]      tc;
        logic [N-1:0]      wrap;
        logic [N-1:0]      ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] load_val;
    logic [3:0] dq   [N];
    logic       dtc  [N];
    logic       dwr  [N];
    logic       dovf [N];

    exp_t sbq[$];
    int   mq [N];
    int   mc [N];
    int   mo [N];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        up_down_counter_param #(
            .WIDTH(4), .MODULO(M_C[g]), .PRESCALE(P_C[g]), .SATURATE(S_C[g] != 0)
        ) dut (
            .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
            .q(dq[g]), .tc(dtc[g]), .wrap(dwr[g]), .ovf_stky(dovf[g])
        );
    end

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, expv);
        end
    endtask

    // Drives one cycle of inputs and pushes the model's expected response for every instance.
    task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l, input logic [3:0] lv);
        exp_t x;
        logic stp, term;
        int   m;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_val = lv;
        x = '0;
        for (int i = 0; i < N; i++) begin
            m    = M_C[i];
            stp  = e && (mc[i] + 1 == P_C[i]);
            term = u ? (mq[i] == m - 1) : (mq[i] == 0);
            x.tc[i] = stp && term;
            if (r) begin
                mq[i] = 0; mc[i] = 0; mo[i] = 0;
            end else if (l) begin
                mq[i] = (int'(lv) >= m) ? m - 1 : int'(lv);
                mc[i] = 0; mo[i] = 0;
            end else if (e) begin
                if (stp) begin
                    mc[i] = 0;
                    if (u) mq[i] = (S_C[i] != 0) ? ((mq[i] == m - 1) ? mq[i] : mq[i] + 1) : (mq[i] + 1) % m;
                    else   mq[i] = (S_C[i] != 0) ? ((mq[i] == 0) ? 0 : mq[i] - 1) : (mq[i] + m - 1) % m;
                end else begin
                    mc[i] = mc[i] + 1;
                end
                x.wrap[i] = stp && term;
                if (stp && term) mo[i] = 1;
            end
            x.q[i] = 4'(mq[i]);
`ifdef UDC_OVF_STICKY_EN
            x.ovf[i] = (mo[i] != 0);
`else
            x.ovf[i] = 1'b0;
`endif
        end
        sbq.push_back(x);
    endtask

    // Monitor: tc is sampled before the edge, registered outputs just after it.
    initial begin : monitor
        exp_t       x;
        logic [N-1:0] tcs;
        forever begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) tcs[i] = dtc[i];
            @(posedge clk); #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                for (int i = 0; i < N; i++) begin
                    checkOutput("tc",   i, 32'(tcs[i]),  32'(x.tc[i]));
                    checkOutput("q",    i, 32'(dq[i]),   32'(x.q[i]));
                    checkOutput("wrap", i, 32'(dwr[i]),  32'(x.wrap[i]));
                    checkOutput("ovf",  i, 32'(dovf[i]), 32'(x.ovf[i]));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
        for (int i = 0; i < N; i++) begin mq[i] = 0; mc[i] = 0; mo[i] = 0; end
        repeat (2) @(posedge clk);

        repeat (3)  applyStimulus(1, 1, 1, 0, 4'd0);
        repeat (20) applyStimulus(0, 1, 1, 0, 4'd0);
        applyStimulus(1, 0, 1, 0, 4'd0);
        repeat (12) applyStimulus(0, 1, 0, 0, 4'd0);
        applyStimulus(0, 0, 0, 1, 4'd12);
        applyStimulus(0, 0, 1, 1, 4'd8);
        repeat (5)  applyStimulus(0, 1, 1, 0, 4'd0);
        applyStimulus(0, 0, 1, 0, 4'd0);
        applyStimulus(0, 1, 1, 1, 4'd2);
        repeat (4)  applyStimulus(0, 1, 1, 0, 4'd0);
        repeat (2)  applyStimulus(0, 0, 1, 0, 4'd0);
        repeat (6)  applyStimulus(0, 1, 1, 0, 4'd0);
        applyStimulus(1, 1, 1, 1, 4'd7);
        applyStimulus(0, 1, 1, 1, 4'd15);
        applyStimulus(0, 1, 1, 1, 4'd3);
        repeat (3)  applyStimulus(0, 1, 0, 0, 4'd0);

        for (int k = 0; k < 500; k++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                          ($urandom % 16) == 0, 4'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain", 0, 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
